// File: rtl/ltc2292_capture.sv
// ---------------------------------------------------------------------------
// ltc2292_capture
//
// Burst capture of LTC2292 channel A/B sample pairs into a small FIFO that
// drains over a valid/ready stream.
//
// A start request in IDLE latches the pair count and the settle delay. The
// block then discards `settle` cycles of samples and makes one FIFO write
// attempt per cycle until `nsamp` attempts have been made. The ADC cannot be
// stalled, so a pair that finds the FIFO full (and no pop in the same cycle)
// is dropped and the sticky overflow flag is raised. Once the burst is
// written the block waits for the FIFO to empty, pulses done and returns to
// IDLE. The stream side runs whenever the FIFO holds data, so draining
// overlaps capture.
//
// Ports
//   clk, rst_n        ADC sample clock; asynchronous active-low reset
//   start             capture request, only honoured in IDLE
//   nsamp             pairs to capture (latched on accepted start)
//   settle            cycles discarded before capture (latched on start)
//   dai, dbi          channel A / B samples, new value every cycle
//   busy              high in every state except IDLE
//   done              one-cycle pulse at the end of a burst
//   overflow          sticky: at least one pair dropped in this burst
//   m_valid/m_ready   stream handshake, pop = m_valid & m_ready
//   m_data            {A, B}, A in the upper DW bits
//   m_last            marks the final captured pair of the burst
// ---------------------------------------------------------------------------
module ltc2292_capture #(
  parameter int DW       = 12,
  parameter int DEPTH    = 16,
  parameter int NSAMP_W  = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NSAMP_W-1:0]  nsamp,
  input  logic [SETTLE_W-1:0] settle,
  input  logic [DW-1:0]       dai,
  input  logic [DW-1:0]       dbi,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2*DW-1:0]     m_data,
  output logic                m_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * DW + 1;  // {last, A, B}

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [NSAMP_W-1:0]  nsamp_q, nsamp_d;
  logic [NSAMP_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;

  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       rd_entry;

  logic                empty;
  logic                full;
  logic                pop;
  logic                wr_req;
  logic                wr_en;
  logic                wr_last;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = m_valid & m_ready;

  // Every CAPTURE cycle is an attempt; a full FIFO still accepts when the
  // head leaves in the same cycle, since the freed slot is the one written.
  assign wr_req  = (state_q == ST_CAPTURE);
  assign wr_en   = wr_req & (~full | pop);
  assign wr_last = (cap_cnt_q == nsamp_q - NSAMP_W'(1));

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    nsamp_d      = nsamp_q;
    cap_cnt_d    = cap_cnt_q;
    settle_cnt_d = settle_cnt_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;

    if (wr_req && !wr_en) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nsamp_d      = nsamp;
          settle_cnt_d = settle;
          cap_cnt_d    = '0;
          overflow_d   = 1'b0;
          if (nsamp == '0) begin
            done_d = 1'b1;  // empty burst: report completion, stay idle
          end else if (settle == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        if (settle_cnt_q == SETTLE_W'(1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cap_cnt_d = cap_cnt_q + NSAMP_W'(1);
        if (wr_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      nsamp_q      <= '0;
      cap_cnt_q    <= '0;
      settle_cnt_q <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      nsamp_q      <= nsamp_d;
      cap_cnt_q    <= cap_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // through the pointers, which are reset, and the outputs are gated below.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {wr_last, dai, dbi};
    end
  end

  assign rd_entry = mem[rd_ptr_q[AW-1:0]];

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign m_valid  = ~empty;
  // Gate the head entry so an empty FIFO presents zeros, never stale data.
  assign m_data   = m_valid ? rd_entry[2*DW-1:0] : '0;
  assign m_last   = m_valid & rd_entry[2*DW];

endmodule
